direct_sound_fifo: RTL and testbench
====================================

// Module: direct_sound_fifo
// PURPOSE
//  Direct Sound channel FIFO fed by CPU/DMA word writes, drained one signed 8-bit PCM
//  sample per overflow of the selected timer (timer0/timer1 genIRQ pulses).
//  Sits directly downstream of the timer blocks in direct_sound; sample_out feeds the mixer.
//  Raises a DMA refill request when the buffered level drops to the threshold.
// PARAMETERS
//  DEPTH_WORDS  8   FIFO depth in 32-bit words (power of 2); byte capacity CAP = 4*DEPTH_WORDS
//  DMA_THRESH   16  byte level at/below which a DMA refill request is issued
// PORTS
//  clock_16     in   1   system clock; sole clock of the block
//  reset        in   1   synchronous, active-high reset
//  timer0_ovf   in   1   timer0 overflow pulse, one clock_16 cycle wide
//  timer1_ovf   in   1   timer1 overflow pulse, one clock_16 cycle wide
//  timer_sel    in   1   0: drain on timer0_ovf, 1: drain on timer1_ovf
//  fifo_clr     in   1   synchronous FIFO clear (SOUNDCNT_H reset bit)
//  wr_en        in   1   word write strobe (FIFO_A/B register write)
//  wr_data      in   32  four samples; byte 0 [7:0] played first, byte 3 [31:24] last
//  sample_out   out  8   current signed PCM sample to mixer
//  dma_req      out  1   one-cycle DMA refill request pulse
//  level        out  $clog2(CAP)+1  bytes currently buffered (0..CAP)
//  full         out  1   level > CAP-4 (next word write would be dropped)
//  empty        out  1   level == 0
//  underflow    out  1   one-cycle pulse: pop requested while empty
// BEHAVIOUR
//  - One clock (clock_16). All state changes on posedge clock_16; no combinational input->output paths.
//  - Reset (sync, active-high): rd/wr pointers 0, level 0, sample_out 8'h00, dma_req 0,
//    underflow 0. full=0, empty=1. Priority: reset > fifo_clr > write/pop.
//  - fifo_clr: same as reset, but sample_out keeps its value. A write/pop in the same cycle is ignored.
//  - pop = timer_sel ? timer1_ovf : timer0_ovf. The unselected timer is ignored.
//    Changing timer_sel takes effect on the same cycle.
//  - Storage: DEPTH_WORDS x 32 array. Write pointer is in words; read pointer is in bytes,
//    log2(CAP) bits. Both pointers wrap modulo their range.
//  - Write: accepted iff wr_en && level <= CAP-4, judged on the pre-cycle level.
//    Word is stored at wr_ptr, wr_ptr+1, level += 4. If not accepted, the write is dropped
//    silently and the state is unchanged.
//  - Pop with level > 0: sample_out <= byte[rd_ptr] on the next edge (1-cycle latency
//    from the ovf pulse). Then rd_ptr+1, level -= 1.
//  - Pop with level == 0: underflow pulses for 1 cycle; pointers and level unchanged;
//    sample_out per CONFIGURATION.
//  - Simultaneous accepted write and pop: both happen; level += 3. A pop on an empty FIFO
//    during a write sees the pre-cycle level, so underflow fires and the written word is not
//    consumed that cycle.
//  - dma_req: pulses for exactly 1 cycle, on the cycle after a pop moves level from
//    > DMA_THRESH to <= DMA_THRESH (including the level+3 write+pop case only if the result
//    crosses downward). No request on reset, on fifo_clr, or while level stays below threshold.
//  - full/empty/level are registered and reflect post-edge state.
// CONFIGURATION
//  DSOUND_HOLD_LAST_EN defined: on underflow, sample_out holds its last value (DC hold).
//  DSOUND_HOLD_LAST_EN undefined (default): on underflow, sample_out <= 8'h00 (silence).
//  All other behaviour is identical in both builds.
// TESTING
//  1. reset=1 for 2 cycles -> sample_out=00, level=0, empty=1, full=0, dma_req=0, underflow=0.
//  2. Write 32'h84_03_02_81, then pulse timer0_ovf x4 (timer_sel=0) -> sample_out 81,02,03,84,
//     each 1 cycle after its pulse; level 4->0; empty=1.
//  3. Fill with 8 writes -> level=32, full=1. 9th write 32'hDEADBEEF is dropped: level stays 32;
//     popping 32 bytes never yields EF.
//  4. From level 32, pop 16 on timer1_ovf with timer_sel=1 -> dma_req pulses exactly once, after
//     the 16th pop (17->16). timer0_ovf pulses in between cause no pops.
//  5. level=0, sample_out=7F, pop -> underflow=1 for 1 cycle. sample_out becomes 00 (default
//     build) or stays 7F (DSOUND_HOLD_LAST_EN build).
//  6. level=5, pop and write in the same cycle -> level=8 and byte order is preserved.
//     Then fifo_clr -> level=0, sample_out unchanged, no dma_req.

Source files
------------

// File: rtl/direct_sound_fifo_if.sv
// Bus bundle between the Direct Sound FIFO and its surroundings: timer pulses, register
// writes, and the sample/status outputs toward the mixer and DMA engine.
interface direct_sound_fifo_if #(
  parameter int DEPTH_WORDS = 8
);
  localparam int LEVEL_W = $clog2(4 * DEPTH_WORDS) + 1;

  logic               timer0_ovf;
  logic               timer1_ovf;
  logic               timer_sel;
  logic               fifo_clr;
  logic               wr_en;
  logic [31:0]        wr_data;
  logic [7:0]         sample_out;
  logic               dma_req;
  logic [LEVEL_W-1:0] level;
  logic               full;
  logic               empty;
  logic               underflow;

  modport slave (
    input  timer0_ovf, timer1_ovf, timer_sel, fifo_clr, wr_en, wr_data,
    output sample_out, dma_req, level, full, empty, underflow
  );

  modport master (
    output timer0_ovf, timer1_ovf, timer_sel, fifo_clr, wr_en, wr_data,
    input  sample_out, dma_req, level, full, empty, underflow
  );
endinterface

// File: rtl/direct_sound_fifo.sv
// Direct Sound channel FIFO: 32-bit word writes in, one PCM byte out per selected timer overflow.
// Build option DSOUND_HOLD_LAST_EN: hold the last sample on underflow instead of emitting silence.
module direct_sound_fifo #(
  parameter int DEPTH_WORDS = 8,
  parameter int DMA_THRESH  = 16
) (
  input  logic                  clock_16,
  input  logic                  reset,
  direct_sound_fifo_if.slave    bus
);

  localparam int CAP   = 4 * DEPTH_WORDS;
  localparam int RP_W  = $clog2(CAP);
  localparam int WP_W  = $clog2(DEPTH_WORDS);
  localparam int LVL_W = RP_W + 1;

  localparam logic [LVL_W-1:0] WR_LIMIT = LVL_W'(CAP - 4);
  localparam logic [LVL_W-1:0] THRESH   = LVL_W'(DMA_THRESH);

  logic [31:0]      mem [DEPTH_WORDS];
  logic [WP_W-1:0]  wr_ptr;
  logic [RP_W-1:0]  rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic [7:0]       sample_q;
  logic             dma_q;
  logic             underflow_q;
  logic             full_q;
  logic             empty_q;

  logic             pop;
  logic             wr_ok;
  logic             pop_ok;
  logic             pop_under;
  logic             cross_down;
  logic [LVL_W-1:0] level_nxt;
  logic [31:0]      rd_word;
  logic [7:0]       rd_byte;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned
  // and a latch is never inferred.
  always_comb begin
    pop        = bus.timer_sel ? bus.timer1_ovf : bus.timer0_ovf;
    wr_ok      = bus.wr_en && (level_q <= WR_LIMIT);
    pop_ok     = pop && (level_q != '0);
    pop_under  = pop && (level_q == '0);

    level_nxt  = level_q;
    if (wr_ok)  level_nxt = level_nxt + LVL_W'(4);
    if (pop_ok) level_nxt = level_nxt - LVL_W'(1);

    cross_down = pop_ok && (level_q > THRESH) && (level_nxt <= THRESH);

    rd_word    = mem[rd_ptr[RP_W-1:2]];
    rd_byte    = rd_word[{rd_ptr[1:0], 3'b000} +: 8];
  end

  // NOTE: the sample storage has no reset; level and pointers alone decide which
  // entries are valid, so clearing the array would buy nothing.
  always_ff @(posedge clock_16) begin
    if (!reset && !bus.fifo_clr && wr_ok) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge
  // values regardless of statement order.
  always_ff @(posedge clock_16) begin
    if (reset || bus.fifo_clr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      dma_q       <= 1'b0;
      underflow_q <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
    end else begin
      if (wr_ok)  wr_ptr <= wr_ptr + WP_W'(1);
      if (pop_ok) rd_ptr <= rd_ptr + RP_W'(1);
      level_q     <= level_nxt;
      dma_q       <= cross_down;
      underflow_q <= pop_under;
      full_q      <= (level_nxt > WR_LIMIT);
      empty_q     <= (level_nxt == '0);
    end
  end

  // fifo_clr leaves the mixer's current sample alone; only reset forces silence.
  always_ff @(posedge clock_16) begin
    if (reset) begin
      sample_q <= 8'h00;
    end else if (!bus.fifo_clr) begin
      if (pop_ok) begin
        sample_q <= rd_byte;
      end else if (pop_under) begin
`ifdef DSOUND_HOLD_LAST_EN
        sample_q <= sample_q;
`else
        sample_q <= 8'h00;
`endif
      end
    end
  end

  assign bus.sample_out = sample_q;
  assign bus.dma_req    = dma_q;
  assign bus.level      = level_q;
  assign bus.full       = full_q;
  assign bus.empty      = empty_q;
  assign bus.underflow  = underflow_q;

endmodule

// File: tb/tb_direct_sound_fifo.sv
// Scoreboard bench for direct_sound_fifo: expected bytes are queued on accepted writes
// and popped as the selected timer drains them; status outputs are checked every cycle.
module tb_direct_sound_fifo;

  localparam int DEPTH_WORDS = 8;
  localparam int CAP         = 4 * DEPTH_WORDS;
  localparam int THRESH      = 16;

  logic clock_16 = 1'b0;
  logic reset    = 1'b1;

  always #5 clock_16 = ~clock_16;

  direct_sound_fifo_if #(.DEPTH_WORDS(DEPTH_WORDS)) bus ();

  direct_sound_fifo #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .DMA_THRESH  (THRESH)
  ) dut (
    .clock_16 (clock_16),
    .reset    (reset),
    .bus      (bus)
  );

  logic [7:0] sb [$];
  logic [7:0] exp_sample = 8'h00;
  logic       exp_dma    = 1'b0;
  logic       exp_under  = 1'b0;
  int         vectors    = 0;
  int         miscompares = 0;
  int         dma_count  = 0;
  bit         seen_ef    = 1'b0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Called at a negedge: drive one cycle of inputs, advance the model, check after the edge.
  task automatic step(input bit rst, input bit wr, input logic [31:0] data,
                      input bit t0, input bit t1, input bit sel, input bit clr);
    int pre;
    bit pop;
    bit wr_ok;
    int post;
    reset          = rst;
    bus.wr_en      = wr;
    bus.wr_data    = data;
    bus.timer0_ovf = t0;
    bus.timer1_ovf = t1;
    bus.timer_sel  = sel;
    bus.fifo_clr   = clr;

    pre       = sb.size();
    pop       = sel ? t1 : t0;
    wr_ok     = wr && (pre <= CAP - 4);
    exp_dma   = 1'b0;
    exp_under = 1'b0;
    if (rst) begin
      sb.delete();
      exp_sample = 8'h00;
    end else if (clr) begin
      sb.delete();
    end else begin
      if (pop && pre > 0) begin
        exp_sample = sb.pop_front();
        post = pre - 1 + (wr_ok ? 4 : 0);
        if (pre > THRESH && post <= THRESH) exp_dma = 1'b1;
      end else if (pop) begin
        exp_under = 1'b1;
`ifndef DSOUND_HOLD_LAST_EN
        exp_sample = 8'h00;
`endif
      end
      if (wr_ok) begin
        for (int i = 0; i < 4; i++) sb.push_back(data[8*i +: 8]);
      end
    end

    @(negedge clock_16);
    check("sample_out", 32'(bus.sample_out), 32'(exp_sample));
    check("level",      32'(bus.level),      32'(sb.size()));
    check("empty",      32'(bus.empty),      32'(sb.size() == 0));
    check("full",       32'(bus.full),       32'(sb.size() > CAP - 4));
    check("dma_req",    32'(bus.dma_req),    32'(exp_dma));
    check("underflow",  32'(bus.underflow),  32'(exp_under));
    dma_count += int'(bus.dma_req);
    if (bus.sample_out === 8'hEF) seen_ef = 1'b1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic write_word(input logic [31:0] data);
    step(1'b0, 1'b1, data, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_t0();
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.wr_en      = 1'b0;
    bus.wr_data    = 32'h0;
    bus.timer0_ovf = 1'b0;
    bus.timer1_ovf = 1'b0;
    bus.timer_sel  = 1'b0;
    bus.fifo_clr   = 1'b0;
    @(negedge clock_16);

    // Reset held for two cycles.
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();

    // Single word, drained in byte order on timer0.
    write_word(32'h84_03_02_81);
    repeat (4) pop_t0();
    idle();

    // Fill to capacity; the ninth write must be dropped.
    for (int w = 0; w < 8; w++) begin
      write_word({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
    end
    write_word(32'hDEAD_BEEF);
    check("level_after_drop", 32'(bus.level), 32'(CAP));

    // Drain 16 on timer1 with stray timer0 pulses in between; one DMA request at 17->16.
    dma_count = 0;
    seen_ef   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    check("dma_pulses", 32'(dma_count), 32'd1);
    repeat (16) pop_t0();
    check("no_dropped_byte", 32'(seen_ef), 32'd0);
    idle();

    // Underflow after the last byte 7F.
    write_word(32'h7F_00_00_00);
    repeat (4) pop_t0();
    pop_t0();
    idle();

    // level 5, then simultaneous write and pop, then clear with traffic present.
    write_word(32'h13_12_11_10);
    write_word(32'h17_16_15_14);
    repeat (3) pop_t0();
    step(1'b0, 1'b1, 32'h1B_1A_19_18, 1'b1, 1'b0, 1'b0, 1'b0);
    check("level_wr_pop", 32'(bus.level), 32'd8);
    repeat (2) pop_t0();
    step(1'b0, 1'b1, 32'hAA_BB_CC_DD, 1'b1, 1'b0, 1'b0, 1'b1);
    idle();

    // Pop on empty in the same cycle as a write; timer_sel switching on the same cycle.
    step(1'b0, 1'b1, 32'h44_33_22_11, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset mid-stream returns the sample to silence.
    step(1'b1, 1'b1, 32'h55_55_55_55, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
